ex_alu_muldiv: RTL

//  Next-generation EX-stage execute unit for the pipelined MIPS core: width-parametrised ALU with

---
 rtl/ex_alu_muldiv_pkg.sv | 26 ++
 rtl/ex_alu_muldiv_if.sv | 33 +++
 rtl/ex_alu_muldiv_muldiv_iter.sv | 88 ++++++++
 rtl/ex_alu_muldiv.sv | 110 +++++++++++
 4 files changed

// File: rtl/ex_alu_muldiv_pkg.sv
// ex_alu_pkg: shared op codes, forwarding select codes and mult/div FSM states for the EX unit
package ex_alu_pkg;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_MULT  = 4'b0011;
    localparam logic [3:0] ALU_MULTU = 4'b0100;
    localparam logic [3:0] ALU_DIV   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MFHI  = 4'b1101;
    localparam logic [3:0] ALU_MFLO  = 4'b1110;

    localparam logic [1:0] FWD_CUR   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_e;

    function automatic logic is_muldiv(input logic [3:0] c);
        return (c == ALU_MULT) || (c == ALU_MULTU) || (c == ALU_DIV) || (c == ALU_DIVU);
    endfunction
endpackage

// File: rtl/ex_alu_muldiv_if.sv
// ex_alu_muldiv_if: ID/EX request, hazard-unit selects and EX/MEM result bundle of the execute unit
interface ex_alu_muldiv_if #(parameter int WIDTH = 32);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic             alu_src;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] read2;
    logic [15:0]      imm16;
    logic [WIDTH-1:0] ex_mem_fwd;
    logic [WIDTH-1:0] mem_wb_fwd;
    logic [1:0]       c_data1_src;
    logic [1:0]       c_data2_src;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] store_data;
    logic             busy;
    logic             fwd_err;

    modport master (
        output flush, in_valid, alu_ctrl, alu_src, data1, read2, imm16,
               ex_mem_fwd, mem_wb_fwd, c_data1_src, c_data2_src,
        input  in_ready, out_valid, result, zero, store_data, busy, fwd_err
    );

    modport slave (
        input  flush, in_valid, alu_ctrl, alu_src, data1, read2, imm16,
               ex_mem_fwd, mem_wb_fwd, c_data1_src, c_data2_src,
        output in_ready, out_valid, result, zero, store_data, busy, fwd_err
    );
endinterface

// File: rtl/ex_alu_muldiv_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider on magnitudes with sign fixup
module muldiv_iter import ex_alu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d, p_step, prod;
    logic [WIDTH-1:0]   b_q, b_d, mag_a, mag_b, q_fix, r_fix;
    logic               qneg_q, qneg_d, rneg_q, rneg_d, sa, sb;
    logic [WIDTH:0]     msum, shifted, trial;

    assign sa      = is_signed & a[WIDTH-1];
    assign sb      = is_signed & b[WIDTH-1];
    assign mag_a   = sa ? -a : a;
    assign mag_b   = sb ? -b : b;
    assign msum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    assign shifted = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, b_q};
    // The last iteration's value feeds the sign fixup directly so HI/LO commit on the same edge.
    assign p_step  = (state_q == MUL) ? {msum, p_q[WIDTH-1:1]}
                   : trial[WIDTH] ? {shifted[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                   : {trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    assign prod    = qneg_q ? -p_step : p_step;
    assign q_fix   = qneg_q ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];
    assign r_fix   = rneg_q ? -p_step[2*WIDTH-1:WIDTH] : p_step[2*WIDTH-1:WIDTH];
    assign hi      = (state_q == MUL) ? prod[2*WIDTH-1:WIDTH] : r_fix;
    assign lo      = (state_q == MUL) ? prod[WIDTH-1:0] : q_fix;
    assign busy    = state_q != IDLE;
    assign done    = busy & ~abort & (cnt_q == CNT_W'(WIDTH - 1));

    // Load magnitudes on start, then one shift/add or shift/subtract per cycle until done or abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        b_d     = b_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (abort) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = is_div ? DIV : MUL;
            cnt_d   = '0;
            p_d     = {{WIDTH{1'b0}}, mag_a};
            b_d     = mag_b;
            // Divide by zero keeps the all-ones quotient and the raw dividend as remainder.
            qneg_d  = (sa ^ sb) & ~(is_div & (b == '0));
            rneg_d  = sa & is_div;
        end else if (busy) begin
            cnt_d = cnt_q + CNT_W'(1);
            p_d   = p_step;
            if (done) state_d = IDLE;
        end
    end

    // Engine state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            b_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            b_q     <= b_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
endmodule

// File: rtl/ex_alu_muldiv.sv
// ex_alu_muldiv: EX stage with forwarding muxes, single-cycle ALU, registered result and HI/LO mult/div
module ex_alu_muldiv import ex_alu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic           clk,
    input logic           reset,
    ex_alu_muldiv_if.slave bus
);
    logic             accept, is_md, md_busy, md_done, md_signed, md_div;
    logic [WIDTH-1:0] op1, rt, op2, imm, alu_res, md_hi, md_lo;
    logic             out_valid_q, out_valid_d, zero_q, zero_d, fwd_err_q, fwd_err_d;
    logic [WIDTH-1:0] result_q, result_d, store_q, store_d, hi_q, hi_d, lo_q, lo_d;

    assign accept    = bus.in_valid & ~md_busy & ~bus.flush;
    assign is_md     = is_muldiv(bus.alu_ctrl);
    assign md_signed = (bus.alu_ctrl == ALU_MULT) | (bus.alu_ctrl == ALU_DIV);
    assign md_div    = (bus.alu_ctrl == ALU_DIV) | (bus.alu_ctrl == ALU_DIVU);
    // Illegal select 11 falls through to the current register value.
    assign op1 = (bus.c_data1_src == FWD_EXMEM) ? bus.ex_mem_fwd
               : (bus.c_data1_src == FWD_MEMWB) ? bus.mem_wb_fwd : bus.data1;
    assign rt  = (bus.c_data2_src == FWD_EXMEM) ? bus.ex_mem_fwd
               : (bus.c_data2_src == FWD_MEMWB) ? bus.mem_wb_fwd : bus.read2;
    assign imm = WIDTH'($signed(bus.imm16));
    assign op2 = bus.alu_src ? imm : rt;

    assign bus.in_ready   = ~md_busy;
    assign bus.busy       = md_busy;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.store_data = store_q;
    assign bus.fwd_err    = fwd_err_q;

    muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .start     (accept & is_md),
        .is_signed (md_signed),
        .is_div    (md_div),
        .abort     (bus.flush),
        .a         (op1),
        .b         (op2),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    // Single-cycle ALU; unknown op codes yield zero.
    always_comb begin
        alu_res = '0;
        case (bus.alu_ctrl)
            ALU_AND:  alu_res = op1 & op2;
            ALU_OR:   alu_res = op1 | op2;
            ALU_ADD:  alu_res = op1 + op2;
            ALU_SUB:  alu_res = op1 - op2;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op1 < op2};
            ALU_NOR:  alu_res = ~(op1 | op2);
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            default:  alu_res = '0;
        endcase
    end

    // Output register: pulse on a single-cycle accept or on engine completion, otherwise hold.
    always_comb begin
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        store_d     = accept ? rt : store_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        fwd_err_d   = fwd_err_q | (accept & ((bus.c_data1_src == 2'b11) | (bus.c_data2_src == 2'b11)));
        if (accept & ~is_md) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = alu_res == '0;
        end
        if (md_done) begin
            out_valid_d = 1'b1;
            result_d    = md_lo;
            zero_d      = md_lo == '0;
            hi_d        = md_hi;
            lo_d        = md_lo;
        end
    end

    // Result, HI/LO and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            store_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            fwd_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            store_q     <= store_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            fwd_err_q   <= fwd_err_d;
        end
    end
endmodule
